// File: rtl/mvm_pkg.sv
// mvm_pkg: shared FSM state type, default sizing and derived widths for the matrix-vector multiplier.
package mvm_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;
    localparam int M_DEF = 20;
    localparam int N_DEF = 20;
    localparam int T_DEF = 8;
    localparam int P_DEF = 1;
    localparam int OUT_W = 2 * T_DEF;
    localparam int A_DEPTH = M_DEF * N_DEF / P_DEF;
    localparam int X_DEPTH = N_DEF / P_DEF;
    function automatic int aw(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction
    localparam int A_AW = aw(A_DEPTH);
    localparam int X_AW = aw(X_DEPTH);
endpackage

// File: rtl/mvm_mac.sv
// mvm_mac: P-lane signed multiply with a wrapping 2T accumulator and registered output.
module mvm_mac #(
    parameter int T = 8,
    parameter int P = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [P*T-1:0]   a,
    input  logic [P*T-1:0]   x,
    output logic [2*T-1:0]   acc
);
    localparam int OW = 2 * T;
    logic [OW-1:0] sum, acc_d, acc_q;
    always_comb begin
        sum = '0;
        for (int p = 0; p < P; p++)
            sum = sum + OW'($signed(a[p*T +: T]) * $signed(x[p*T +: T]));
        acc_d = en ? (clr ? '0 : acc_q) + sum : acc_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else acc_q <= acc_d;
    end
    assign acc = acc_q;
endmodule

// File: rtl/mvm.sv
// mvm: serially loaded M x N matrix and N vector, computes y = A*x on P MAC lanes and streams y out.
module mvm
    import mvm_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int T = T_DEF,
    parameter int P = P_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadMatrix,
    input  logic             loadVector,
    input  logic             start,
    output logic             done,
    input  logic [T-1:0]     data_in,
    output logic [2*T-1:0]   data_out
);
    localparam int OW = 2 * T;
    localparam int AD = M * N / P;
    localparam int XD = N / P;
    localparam int AW = aw(AD);
    localparam int XW = aw(XD);
    localparam int RW = aw(M);
    localparam int LW = aw(P);
    localparam int CW = aw(AD + M + 2);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [XW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d, rrow_q, rrow_d;
    logic rd_q, rd_d, done_q, done_d;
    logic [OW-1:0] data_out_q, data_out_d, mac_out;
    logic [P*T-1:0] a_flat, x_flat;
    logic [OW-1:0] y_buf [M];
    logic issue, col_last, lane_last;

    assign issue = state_q == COMPUTE && cnt_q < CW'(AD);
    assign col_last = col_q == XW'(XD - 1);
    assign lane_last = lane_q == LW'(P - 1);

    // Bank g holds every P-th word, so one address reads P adjacent columns of a row.
    for (genvar g = 0; g < P; g++) begin : bank
        logic [T-1:0] a_mem [AD];
        logic [T-1:0] x_mem [XD];
        always_ff @(posedge clk) begin
            if (state_q == LOAD_A && lane_q == LW'(g)) a_mem[cnt_q[AW-1:0]] <= data_in;
            if (state_q == LOAD_X && lane_q == LW'(g)) x_mem[cnt_q[XW-1:0]] <= data_in;
        end
        assign a_flat[g*T +: T] = a_mem[cnt_q[AW-1:0]];
        assign x_flat[g*T +: T] = x_mem[col_q];
    end

    mvm_mac #(.T(T), .P(P)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (issue),
        .clr   (col_q == '0),
        .a     (a_flat),
        .x     (x_flat),
        .acc   (mac_out)
    );

    // A finished row sits in the accumulator for one cycle before the next row overwrites it.
    always_ff @(posedge clk) begin
        if (rd_q) y_buf[rrow_q] <= mac_out;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        lane_d = lane_q;
        col_d = col_q;
        row_d = row_q;
        done_d = 1'b0;
        data_out_d = '0;
        rd_d = issue && col_last;
        rrow_d = row_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                lane_d = '0;
                col_d = '0;
                row_d = '0;
                state_d = loadMatrix ? LOAD_A : loadVector ? LOAD_X : start ? COMPUTE : IDLE;
            end
            LOAD_A, LOAD_X: begin
                lane_d = lane_last ? '0 : lane_q + 1'b1;
                cnt_d = lane_last ? cnt_q + 1'b1 : cnt_q;
                if (lane_last && cnt_q == (state_q == LOAD_A ? CW'(AD - 1) : CW'(XD - 1)))
                    state_d = IDLE;
            end
            COMPUTE: begin
                cnt_d = cnt_q + 1'b1;
                if (issue) begin
                    col_d = col_last ? '0 : col_q + 1'b1;
                    row_d = col_last ? row_q + 1'b1 : row_q;
                end
                // Two extra cycles drain the MAC register and the last buffer write.
                if (cnt_q == CW'(AD + 1)) begin
                    state_d = OUTPUT;
                    cnt_d = '0;
                    done_d = 1'b1;
                end
            end
            OUTPUT: begin
                data_out_d = y_buf[cnt_q[RW-1:0]];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(M - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            lane_q <= '0;
            col_q <= '0;
            row_q <= '0;
            rrow_q <= '0;
            rd_q <= 1'b0;
            done_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            lane_q <= lane_d;
            col_q <= col_d;
            row_q <= row_d;
            rrow_q <= rrow_d;
            rd_q <= rd_d;
            done_q <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign done = done_q;
    assign data_out = data_out_q;
endmodule

// File: tb/tb_mvm.sv
// tb_mvm: table-driven and randomized checks of mvm against an arithmetic y = A*x reference.
module tb_mvm;
    localparam int M = 20;
    localparam int N = 20;
    localparam int T = 8;
    localparam int P = 1;
    localparam int LAT = M * N / P + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loadMatrix = 1'b0;
    logic loadVector = 1'b0;
    logic start = 1'b0;
    logic done;
    logic [T-1:0] data_in = '0;
    logic [2*T-1:0] data_out;

    always #5 clk = ~clk;

    mvm #(.M(M), .N(N), .T(T), .P(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .loadMatrix (loadMatrix),
        .loadVector (loadVector),
        .start      (start),
        .done       (done),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    typedef struct {
        int a;
        int x;
        int y;
    } vec_t;

    vec_t tbl[6];
    int cmp = 0;
    int mis = 0;
    int A[M][N];
    int X[N];
    logic [15:0] yexp[M];

    task automatic check(input string nm, input int act, input int exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int inject);
        loadMatrix = 1'b1;
        tick();
        loadMatrix = 1'b0;
        for (int k = 0; k < M * N; k++) begin
            data_in = T'(A[k / N][k % N]);
            start = (k == inject);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic load_x;
        loadVector = 1'b1;
        tick();
        loadVector = 1'b0;
        for (int k = 0; k < N; k++) begin
            data_in = T'(X[k]);
            tick();
        end
    endtask

    task automatic model;
        for (int i = 0; i < M; i++) begin
            int s = 0;
            for (int k = 0; k < N; k++) s += A[i][k] * X[k];
            yexp[i] = 16'(s);
        end
    endtask

    task automatic rand_fill(input bit do_a, input bit do_x);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < N; k++)
                if (do_a) A[i][k] = int'($urandom_range(0, 79)) - 40;
        for (int k = 0; k < N; k++)
            if (do_x) X[k] = int'($urandom_range(0, 79)) - 40;
    endtask

    // Edge e counts clock edges after the one that samples start.
    task automatic run(input string nm, input int abort_at, input int cmd_at);
        int first = -1;
        int nd = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= LAT + M; e++) begin
            loadMatrix = (e == cmd_at);
            if (e == abort_at) begin
                reset = 1'b1;
                #1;
                check({nm, "_rst_done"}, int'(done), 0);
                check({nm, "_rst_dout"}, int'(data_out), 0);
                tick();
                check({nm, "_rst_dout_held"}, int'(data_out), 0);
                reset = 1'b0;
                break;
            end
            tick();
            if (done) begin
                nd++;
                if (first < 0) first = e;
            end
            if (e > LAT)
                check($sformatf("%s_y%0d", nm, e - LAT - 1), int'(data_out), int'(yexp[e - LAT - 1]));
        end
        loadMatrix = 1'b0;
        if (abort_at < 0) begin
            check({nm, "_done_edge"}, first, LAT);
            check({nm, "_done_count"}, nd, 1);
        end
    endtask

    initial begin
        tbl[0] = '{a: 1,    x: 2,    y: 40};
        tbl[1] = '{a: -40,  x: -40,  y: 32000};
        tbl[2] = '{a: 0,    x: 5,    y: 0};
        tbl[3] = '{a: 39,   x: -40,  y: -31200};
        tbl[4] = '{a: 127,  x: 127,  y: -5100};
        tbl[5] = '{a: -128, x: -128, y: 0};

        tick();
        tick();
        check("reset_done", int'(done), 0);
        check("reset_dout", int'(data_out), 0);
        reset = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < M; i++) begin
                for (int k = 0; k < N; k++) A[i][k] = tbl[t].a;
                yexp[i] = 16'(tbl[t].y);
            end
            for (int k = 0; k < N; k++) X[k] = tbl[t].x;
            load_a(-1);
            load_x();
            run($sformatf("fill%0d", t), -1, -1);
        end

        for (int i = 0; i < M; i++)
            for (int k = 0; k < N; k++) A[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < N; k++) X[k] = k - 10;
        for (int j = 0; j < M; j++) yexp[j] = 16'(j - 10);
        load_a(-1);
        load_x();
        run("ident", -1, -1);

        for (int r = 0; r < 3; r++) begin
            rand_fill(1'b1, 1'b1);
            load_a(-1);
            load_x();
            model();
            run($sformatf("rand%0d", r), -1, -1);
        end

        rand_fill(1'b0, 1'b1);
        load_x();
        model();
        run("newx", -1, -1);
        run("b2b", -1, -1);

        run("abort", LAT + 5, -1);
        tick();
        run("post_rst", -1, -1);

        rand_fill(1'b1, 1'b0);
        load_a(37);
        model();
        run("ign_load", -1, LAT + 5);
        run("after_ign", -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
